// File: rtl/cfg_bus_pkg.sv
// cfg_bus_pkg: constants and field widths of the instrumentation
// reconfiguration bus, shared by the broadcaster and the receiving units.
//   CFG_IDLE_ID    - configId value meaning "no unit addressed"
//   CFG_END_MARKER - header ID that terminates a configuration session
//   ST_*           - broadcaster FSM state encoding
package cfg_bus_pkg;

  localparam int CFG_ID_W   = 8;
  localparam int CFG_LEN_W  = 8;
  localparam int CFG_DATA_W = 8;

  localparam logic [CFG_ID_W-1:0] CFG_IDLE_ID    = 8'hFF;
  localparam logic [CFG_ID_W-1:0] CFG_END_MARKER = 8'hFE;

  typedef logic [3:0] cfg_state_t;

  localparam cfg_state_t ST_IDLE    = 4'd0;
  localparam cfg_state_t ST_DRAIN   = 4'd1;
  localparam cfg_state_t ST_HDR_ID  = 4'd2;
  localparam cfg_state_t ST_HDR_LEN = 4'd3;
  localparam cfg_state_t ST_LOAD    = 4'd4;
  localparam cfg_state_t ST_DISCARD = 4'd5;
  localparam cfg_state_t ST_SEND    = 4'd6;
  localparam cfg_state_t ST_GAP     = 4'd7;
  localparam cfg_state_t ST_RESUME  = 4'd8;
  localparam cfg_state_t ST_CHECK   = 4'd9;

endpackage

// File: rtl/config_broadcaster.sv
// config_broadcaster: transmit side of the instrumentation reconfiguration
// bus. Takes a host byte stream of {ID, LEN, payload} messages, buffers each
// payload and replays it to the addressed unit as one unbroken burst, followed
// by one idle-ID cycle so receiver byte counters restart.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start_cfg           - one-cycle session request (sampled in IDLE only)
//   host_valid/ready/data - host byte stream handshake
//   pause_req           - asks upstream to stop issuing valid_in
//   tracing             - 1 = normal tracing, 0 = reconfiguring
//   configId/configData - reconfiguration bus to the instrumentation chain
//   cfg_done            - one-cycle pulse when the session ends
//   cfg_err             - sticky error, cleared by an accepted start_cfg
//
// Build option: define CFG_CHECKSUM_EN to require a trailing 8-bit sum byte
// (ID + LEN + payload) on every non-END message; a mismatch drops the message.
// DRAIN_CYCLES must be at least 1.
module config_broadcaster
  import cfg_bus_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         DRAIN_CYCLES   = 8,
  parameter logic [7:0] IDLE_CONFIG_ID = CFG_IDLE_ID,
  parameter logic [7:0] END_MARKER     = CFG_END_MARKER
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_cfg,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic [7:0] host_data,
  output logic       pause_req,
  output logic       tracing,
  output logic [7:0] configId,
  output logic [7:0] configData,
  output logic       cfg_done,
  output logic       cfg_err
);

  localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_W      = CNT_W'(MAX_PAYLOAD);

`ifdef CFG_CHECKSUM_EN
  localparam cfg_state_t ST_AFTER_LOAD  = ST_CHECK;
  localparam cfg_state_t ST_AFTER_EMPTY = ST_CHECK;
`else
  localparam cfg_state_t ST_AFTER_LOAD  = ST_SEND;
  localparam cfg_state_t ST_AFTER_EMPTY = ST_GAP;
`endif

  cfg_state_t       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       id_q, len_q;
  logic [7:0]       pbuf [MAX_PAYLOAD];
  logic             accept, err_set, pay_last, disc_last;
  logic [CNT_W-1:0] len_w, rd_idx;
  logic [7:0]       data_n;

  assign accept   = host_valid & host_ready;
  assign len_w    = CNT_W'(len_q);
  assign pay_last = (cnt == len_w - ONE);

`ifdef CFG_CHECKSUM_EN
  logic [7:0] sum_q;
  // an oversized message still carries its trailing sum byte
  assign disc_last = (cnt == len_w);

  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else if (accept) begin
      case (state)
        ST_HDR_ID:           sum_q <= host_data;
        ST_HDR_LEN, ST_LOAD: sum_q <= sum_q + host_data;
        default: ;
      endcase
    end
  end
`else
  assign disc_last = pay_last;
`endif

  always_comb begin
    state_n = state;
    err_set = 1'b0;
    case (state)
      ST_IDLE:    if (start_cfg) state_n = ST_DRAIN;
      ST_DRAIN:   if (cnt == DRAIN_LAST) state_n = ST_HDR_ID;
      ST_HDR_ID:  if (accept) state_n = (host_data == END_MARKER) ? ST_RESUME : ST_HDR_LEN;
      ST_HDR_LEN: if (accept) begin
        if (host_data == 8'd0) state_n = ST_AFTER_EMPTY;
        else if (CNT_W'(host_data) > MAX_W) begin
          state_n = ST_DISCARD;
          err_set = 1'b1;
        end else state_n = ST_LOAD;
      end
      ST_LOAD:    if (accept && pay_last) state_n = ST_AFTER_LOAD;
      ST_DISCARD: if (accept && disc_last) state_n = ST_HDR_ID;
`ifdef CFG_CHECKSUM_EN
      ST_CHECK:   if (accept) begin
        if (host_data == sum_q) state_n = (len_q == 8'd0) ? ST_GAP : ST_SEND;
        else begin
          state_n = ST_HDR_ID;
          err_set = 1'b1;
        end
      end
`endif
      ST_SEND:    if (pay_last) state_n = ST_GAP;
      ST_GAP:     state_n = ST_HDR_ID;
      ST_RESUME:  state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Byte to put on the bus next cycle. When a 1-byte message goes straight
  // from LOAD to SEND, its only byte is being written this same edge, so it
  // is forwarded from host_data instead of read from the buffer.
  always_comb begin
    rd_idx = '0;
    if (state == ST_SEND) rd_idx = cnt + ONE;
    if (state == ST_LOAD && cnt == '0) data_n = host_data;
    else if (rd_idx < MAX_W)           data_n = pbuf[rd_idx[IDX_W-1:0]];
    else                               data_n = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // cnt restarts on every state change; it counts drain cycles, bytes
  // accepted in LOAD/DISCARD, and bytes already driven in SEND.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (state_n != state) cnt <= '0;
    else if (state == ST_DRAIN || state == ST_SEND ||
             ((state == ST_LOAD || state == ST_DISCARD) && accept))
      cnt <= cnt + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q  <= '0;
      len_q <= '0;
    end else if (accept) begin
      if (state == ST_HDR_ID)  id_q  <= host_data;
      if (state == ST_HDR_LEN) len_q <= host_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_LOAD && accept) pbuf[cnt[IDX_W-1:0]] <= host_data;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tracing    <= 1'b1;
      pause_req  <= 1'b0;
      host_ready <= 1'b0;
      configId   <= IDLE_CONFIG_ID;
      configData <= 8'd0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      tracing    <= state_n inside {ST_IDLE, ST_DRAIN, ST_RESUME};
      pause_req  <= !(state_n inside {ST_IDLE, ST_RESUME});
      host_ready <= state_n inside {ST_HDR_ID, ST_HDR_LEN, ST_LOAD, ST_DISCARD, ST_CHECK};
      configId   <= (state_n == ST_SEND) ? id_q : IDLE_CONFIG_ID;
      if (state_n == ST_SEND) configData <= data_n;
      cfg_done   <= (state_n == ST_RESUME);
      if (state == ST_IDLE && start_cfg) cfg_err <= 1'b0;
      else if (err_set)                  cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_config_broadcaster.sv
// tb_config_broadcaster: randomized and directed sessions against a
// message-level model (expected bursts per message, latency rules).
module tb_config_broadcaster;

  localparam int         MAXP = 16;
  localparam int         DRN  = 8;
  localparam logic [7:0] IDLE = 8'hFF;
  localparam logic [7:0] ENDM = 8'hFE;
`ifdef CFG_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start_cfg, host_valid;
  logic [7:0] host_data;
  logic       host_ready, pause_req, tracing, cfg_done, cfg_err;
  logic [7:0] configId, configData;

  int total = 0, bad = 0;
  int cyc = 0, send_acc_cyc = -1, done_acc_cyc = -1;
  int done_seen = 0, sessions = 0, rem = 0;
  bit exp_err = 1'b0, gap_due = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] ex_id[$], ex_d[$], obs_id[$], obs_d[$];
  int bl_q[$];

  config_broadcaster #(
    .MAX_PAYLOAD(MAXP), .DRAIN_CYCLES(DRN), .IDLE_CONFIG_ID(IDLE), .END_MARKER(ENDM)
  ) dut (
    .clk(clk), .reset(reset), .start_cfg(start_cfg),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .pause_req(pause_req), .tracing(tracing), .configId(configId),
    .configData(configData), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 2));
  endfunction

  // Bus monitor: every non-idle bus cycle must be the next expected byte of
  // the current burst; bursts are contiguous and followed by an idle cycle.
  always @(negedge clk) begin
    if (reset) begin
      rem = 0; gap_due = 1'b0; prev_data = 8'h00;
    end else begin
      if (gap_due) begin
        check("gap_cycle", 32'(configId), 32'(IDLE));
        gap_due = 1'b0;
      end
      if (configId !== IDLE) begin
        if (rem == 0) begin
          if (bl_q.size() == 0) check("unexpected_burst", 32'(configId), 32'(IDLE));
          else rem = bl_q.pop_front();
        end
        if (rem > 0) begin
          check("burst_id", 32'(configId), 32'(ex_id.pop_front()));
          check("burst_data", 32'(configData), 32'(ex_d.pop_front()));
          check("ready_in_send", 32'(host_ready), 0);
          check("tracing_in_send", 32'(tracing), 0);
          obs_id.push_back(configId);
          obs_d.push_back(configData);
          rem--;
          if (rem == 0) gap_due = 1'b1;
        end
      end else begin
        if (rem != 0) begin
          check("burst_contiguous", 32'(configId), 32'(ex_id[0]));
          while (rem > 0) begin void'(ex_id.pop_front()); void'(ex_d.pop_front()); rem--; end
        end
        check("data_hold", 32'(configData), 32'(prev_data));
      end
      prev_data = configData;
      if (cyc == send_acc_cyc) check("send_latency", 32'(configId !== IDLE), 1);
      if (cyc == done_acc_cyc) begin
        check("done_pulse", 32'(cfg_done), 1);
        check("resume_tracing", 32'(tracing), 1);
        check("resume_pause", 32'(pause_req), 0);
      end
      if (cfg_done) done_seen++;
    end
  end

  // Offer one byte (after 'idle' stall cycles) and wait for its handshake.
  // tag 1: last byte before a burst, tag 2: END marker.
  task automatic send_byte(input logic [7:0] b, input int idle, input int tag);
    int n; bit got; logic rdy;
    host_valid = 1'b0;
    repeat (idle) begin host_data = 8'($urandom); @(negedge clk); end
    host_valid = 1'b1; host_data = b; got = 1'b0; n = 0;
    while (!got && n < 100) begin
      rdy = host_ready;
      @(posedge clk); #1;
      if (rdy) begin
        got = 1'b1;
        if (tag == 1) send_acc_cyc = cyc;
        if (tag == 2) done_acc_cyc = cyc;
      end
      n++;
      @(negedge clk);
    end
    host_valid = 1'b0;
    check("byte_accepted_in_time", 32'(got), 1);
  endtask

  // base != 0 gives payload base, 2*base, ...; base == 0 gives random payload.
  task automatic msg(input logic [7:0] id, input int len, input logic [7:0] base,
                     input int stall_last, input bit bad_sum);
    logic [7:0] pl[$];
    logic [7:0] s;
    bit ok;
    int tg;
    ok = (len > 0) && (len <= MAXP) && !bad_sum;
    for (int k = 0; k < len; k++) pl.push_back(base != 0 ? 8'(base * (k + 1)) : 8'($urandom));
    if (len > MAXP || bad_sum) exp_err = 1'b1;
    s = id + 8'(len);
    foreach (pl[k]) s += pl[k];
    if (ok) begin
      bl_q.push_back(len);
      foreach (pl[k]) begin ex_id.push_back(id); ex_d.push_back(pl[k]); end
    end
    send_byte(id, rnd(), 0);
    send_byte(8'(len), rnd(), 0);
    for (int k = 0; k < len; k++) begin
      tg = (k == len - 1 && ok && !CHK) ? 1 : 0;
      send_byte(pl[k], (k == len - 1 && stall_last > 0) ? stall_last : rnd(), tg);
    end
    if (CHK) send_byte(bad_sum ? s + 8'd1 : s, rnd(), ok ? 1 : 0);
  endtask

  task automatic begin_session();
    int lat;
    exp_err = 1'b0;
    obs_id.delete(); obs_d.delete();
    // an END byte offered in IDLE/DRAIN must not be consumed
    start_cfg = 1'b1; host_valid = 1'b1; host_data = ENDM;
    @(negedge clk);
    start_cfg = 1'b0;
    check("pause_after_start", 32'(pause_req), 1);
    check("err_cleared", 32'(cfg_err), 0);
    lat = 1;
    while (tracing && lat < 40) begin @(negedge clk); lat++; end
    check("drain_latency", 32'(lat), 32'(1 + DRN));
    host_valid = 1'b0;
  endtask

  task automatic end_session();
    send_byte(ENDM, rnd(), 2);
    sessions++;
    @(negedge clk);
    check("err_final", 32'(cfg_err), 32'(exp_err));
    check("idle_ready", 32'(host_ready), 0);
    check("idle_tracing", 32'(tracing), 1);
    check("bursts_drained", 32'(bl_q.size()), 0);
    check("done_count", 32'(done_seen), 32'(sessions));
  endtask

  initial begin
    reset = 1'b1; start_cfg = 1'b0; host_valid = 1'b0; host_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tracing", 32'(tracing), 1);
    check("rst_pause", 32'(pause_req), 0);
    check("rst_id", 32'(configId), 32'hFF);
    check("rst_data", 32'(configData), 0);
    check("rst_ready", 32'(host_ready), 0);
    check("rst_done", 32'(cfg_done), 0);
    check("rst_err", 32'(cfg_err), 0);
    reset = 1'b0;
    @(negedge clk);

    // {02,3,11,22,33} then END
    begin_session(); msg(8'h02, 3, 8'h11, 0, 1'b0); end_session();
    check("lit_s1_count", 32'(obs_id.size()), 3);
    check("lit_s1_id", 32'(obs_id[0]), 32'h02);
    check("lit_s1_d0", 32'(obs_d[0]), 32'h11);
    check("lit_s1_d1", 32'(obs_d[1]), 32'h22);
    check("lit_s1_d2", 32'(obs_d[2]), 32'h33);

    // same message, host stalls before the last byte
    begin_session(); msg(8'h02, 3, 8'h11, 4, 1'b0); end_session();
    check("lit_s2_count", 32'(obs_id.size()), 3);
    check("lit_s2_d2", 32'(obs_d[2]), 32'h33);

    // two messages to the same ID
    begin_session(); msg(8'h01, 2, 8'h00, 0, 1'b0); msg(8'h01, 2, 8'h00, 0, 1'b0); end_session();
    check("lit_s3_count", 32'(obs_id.size()), 4);
    check("lit_s3_id3", 32'(obs_id[3]), 32'h01);

    // oversized message discarded, stray start_cfg ignored, next message sent
    begin_session();
    msg(8'h07, 20, 8'h00, 0, 1'b0);
    start_cfg = 1'b1; @(negedge clk); start_cfg = 1'b0;
    msg(8'h04, 2, 8'h11, 0, 1'b0);
    end_session();
    check("lit_s4_err", 32'(cfg_err), 1);
    check("lit_s4_count", 32'(obs_id.size()), 2);
    check("lit_s4_id", 32'(obs_id[0]), 32'h04);

`ifdef CFG_CHECKSUM_EN
    begin_session(); msg(8'h03, 1, 8'h05, 0, 1'b0); end_session();
    check("lit_ck_ok_count", 32'(obs_d.size()), 1);
    check("lit_ck_ok_d0", 32'(obs_d[0]), 32'h05);
    check("lit_ck_ok_err", 32'(cfg_err), 0);
    begin_session(); msg(8'h03, 1, 8'h05, 0, 1'b1); end_session();
    check("lit_ck_bad_count", 32'(obs_d.size()), 0);
    check("lit_ck_bad_err", 32'(cfg_err), 1);
`endif

    // randomized sessions
    repeat (8) begin
      begin_session();
      repeat ($urandom_range(1, 4))
        msg(8'($urandom_range(0, 253)), int'($urandom_range(0, 20)), 8'h00, 0, 1'b0);
      end_session();
    end

    // reset in the middle of a payload
    begin_session();
    send_byte(8'h05, 0, 0); send_byte(8'h04, 0, 0); send_byte(8'hAA, 0, 0);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check("midrst_pause", 32'(pause_req), 0);
    check("midrst_tracing", 32'(tracing), 1);
    check("midrst_ready", 32'(host_ready), 0);
    check("midrst_id", 32'(configId), 32'hFF);
    reset = 1'b0;
    @(negedge clk);
    begin_session(); msg(8'h09, 2, 8'h21, 0, 1'b0); end_session();
    check("lit_post_rst_d1", 32'(obs_d[1]), 32'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
